riscv_core_div_unit: RTL and testbench
======================================

Name: riscv_core_div_unit

Overview:
- Iterative RV64M divider/remainder unit sitting in EX beside the ALU.
- It is the requesting side of the stall interface that the hazard unit serves. It raises a stall request while a DIV/DIVU/REM/REMU (and W forms) is in flight, and accepts the hazard unit's EX flush as an abort.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_div_unit_valid_ex  in  1  divide-class op present in EX
- i_div_unit_op_ex  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_div_unit_word_ex  in  1  1 = W form (DIVW/DIVUW/REMW/REMUW)
- i_div_unit_srca_ex  in  64  dividend, already forwarded
- i_div_unit_srcb_ex  in  64  divisor, already forwarded
- i_div_unit_flush_ex  in  1  EX flush from hazard unit; aborts operation
- o_div_unit_stall_req  out  1  to hazard unit; stalls IF/ID/EX
- o_div_unit_done  out  1  single-cycle result-valid pulse
- o_div_unit_result  out  64  quotient or remainder

Behaviour:
- Registered state machine: IDLE, CALC, FIX, DONE. Reset (i_rst_n=0 at clock edge) forces IDLE, clears counter and accumulators, and drives o_done=0 and o_result=0. Reset mid-operation discards the operation.
- IDLE: when valid_ex=1 and flush_ex=0, capture operands:
  - Signed ops (DIV/REM): convert both operands to magnitudes; record quotient sign = sa^sb and remainder sign = sa.
  - W forms: use bits[31:0], sign-extended for DIV/REM or zero-extended for DIVU/REMU; iteration count 32.
  - Otherwise iteration count 64.
- Special cases go IDLE -> DONE directly (latency 1):
  - Divisor = 0: quotient = all ones; remainder = dividend (the W-extended value).
  - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
  - Otherwise IDLE -> CALC.
- CALC: each cycle shift {rem, quo} left by 1, subtract divisor from rem, keep the difference if non-negative, and shift in the quotient bit. The counter decrements; when it reaches 0, go to FIX.
- FIX: apply sign correction (two's complement), select quotient or remainder per op, and for W forms sign-extend bit 31 to 64 (all W ops, including unsigned). Then go to DONE.
- DONE: o_done=1 for exactly one cycle, result registered and stable that cycle. Next state is IDLE.
- Latency:
  - Normal ops: accept + N CALC + FIX + DONE; done appears N+2 cycles after the accept edge (66 for 64-bit, 34 for W).
  - Special cases: done 1 cycle after accept.
- o_stall_req = valid_ex & ~o_done (combinational). Stall is high from the first EX cycle of the op, including the accept cycle, and drops in the DONE cycle so EX advances with the result.
- Flush: flush_ex=1 in any state -> next state IDLE, no result. o_done is gated by ~flush_ex. If flush coincides with the accept cycle, the op is not accepted.
- While busy, operand inputs are ignored. The held EX op is the same instruction because the pipeline is stalled.
- o_result holds its last value outside DONE. It is only meaningful when o_done=1.

Optional Feature:
- Macro: RISCV_CORE_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the dividend magnitude is less than the divisor magnitude (divisor nonzero), go to DONE directly with quotient=0 and remainder=signed dividend; latency 1.
- Undefined: such operands take the full iterative path.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package riscv_core_pkg:
  - div_op_e enum (DIV, DIVU, REM, REMU)
  - div_state_e enum (IDLE, CALC, FIX, DONE)
  - constants DIV_ITER_D=64, DIV_ITER_W=32
- No sub-module; the FSM and datapath stay in one module (about 200 lines).

Test Plan:
- DIVU 100/7, word=0 -> stall_req high 66 cycles; done pulse with result 14. REMU same operands -> 2.
- DIV -7/2 -> result -3 (0xFFFF_FFFF_FFFF_FFFD). REM -7/2 -> -1. Both done at cycle 66.
- DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF. REM 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 and REM -> 0. Each has done 1 cycle after accept.
- DIVW 0x0000_0000_8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000 with done at cycle 1. DIVUW 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF_FFFF_FFFF at cycle 34.
- Flush at CALC cycle 20 -> FSM returns to IDLE, no done pulse. A new DIVU 9/3 then yields 3 at cycle 66.
- Reset (i_rst_n=0) mid-CALC -> IDLE, done=0, result=0. With RISCV_CORE_DIV_EARLY_OUT_EN, DIVU 3/9 -> quotient 0 at cycle 1; without it, at cycle 66.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared core types for the EX-stage divider: op encoding, FSM states, iteration counts.
// Also holds the W-form result formatter, so the special-case and iterative paths agree on it.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    localparam int DIV_ITER_D = 64;
    localparam int DIV_ITER_W = 32;

    // W-form results are always sign-extended from bit 31, including the unsigned ops.
    function automatic logic [63:0] div_fmt(input logic [63:0] v, input logic word);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/riscv_core_div_unit.sv
// Iterative RV64M DIV/DIVU/REM/REMU (+W) unit, radix-2 restoring, one quotient bit per cycle.
// Latency: done N+2 cycles after accept (N=64, or 32 for W); div-by-zero/overflow finish in 1.
// Backpressure: stall_req = valid & ~done; EX flush aborts. RISCV_CORE_DIV_EARLY_OUT_EN adds |a|<|b| early-out.
module riscv_core_div_unit
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_unit_valid_ex,
    input  logic [1:0]      i_div_unit_op_ex,
    input  logic            i_div_unit_word_ex,
    input  logic [XLEN-1:0] i_div_unit_srca_ex,
    input  logic [XLEN-1:0] i_div_unit_srcb_ex,
    input  logic            i_div_unit_flush_ex,
    output logic            o_div_unit_stall_req,
    output logic            o_div_unit_done,
    output logic [XLEN-1:0] o_div_unit_result
);

    div_state_e state_q, state_d;
    div_op_e    op;
    logic [6:0]  cnt_q;
    logic [63:0] rem_q, quo_q, dvs_q, result_q;
    logic        quo_neg_q, rem_neg_q, rem_op_q, word_q;

    logic        is_signed, is_rem, sa, sb, div_zero, ovf, special, accept;
    logic [63:0] a_ext, b_ext, mag_a, mag_b, min_neg, special_res;
    logic [64:0] rem_sh;
    logic        take;
    logic [63:0] q_fix, r_fix, fix_res;

    // Operand conditioning and single-cycle special cases, evaluated in IDLE.
    always_comb begin
        op        = div_op_e'(i_div_unit_op_ex);
        is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        is_rem    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
        if (i_div_unit_word_ex) begin
            a_ext   = {{32{is_signed & i_div_unit_srca_ex[31]}}, i_div_unit_srca_ex[31:0]};
            b_ext   = {{32{is_signed & i_div_unit_srcb_ex[31]}}, i_div_unit_srcb_ex[31:0]};
            min_neg = {{32{1'b1}}, 32'h8000_0000};
        end else begin
            a_ext   = i_div_unit_srca_ex;
            b_ext   = i_div_unit_srcb_ex;
            min_neg = 64'h8000_0000_0000_0000;
        end
        sa       = is_signed & a_ext[63];
        sb       = is_signed & b_ext[63];
        mag_a    = sa ? (~a_ext + 64'd1) : a_ext;
        mag_b    = sb ? (~b_ext + 64'd1) : b_ext;
        div_zero = (b_ext == '0);
        ovf      = is_signed & (b_ext == '1) & (a_ext == min_neg);
        special  = div_zero | ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? a_ext : '1;
        end else if (ovf) begin
            special_res = is_rem ? '0 : a_ext;
        end
`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
        if (!div_zero && (mag_a < mag_b)) begin
            special     = 1'b1;
            special_res = is_rem ? a_ext : '0;
        end
`endif
    end

    // The partial remainder is below the divisor, so the shifted value needs one extra bit.
    always_comb begin
        rem_sh  = {rem_q, quo_q[63]};
        take    = (rem_sh >= {1'b0, dvs_q});
        q_fix   = quo_neg_q ? (~quo_q + 64'd1) : quo_q;
        r_fix   = rem_neg_q ? (~rem_q + 64'd1) : rem_q;
        fix_res = div_fmt(rem_op_q ? r_fix : q_fix, word_q);
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (i_div_unit_valid_ex && !i_div_unit_flush_ex) begin
                    accept  = 1'b1;
                    state_d = special ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: if (cnt_q == 7'd1) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (i_div_unit_flush_ex) state_d = DIV_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_op_q  <= 1'b0;
            word_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        dvs_q     <= mag_b;
                        rem_q     <= '0;
                        // W dividends sit in the top half so 32 shifts leave the quotient in [31:0].
                        quo_q     <= i_div_unit_word_ex ? {mag_a[31:0], 32'b0} : mag_a;
                        cnt_q     <= i_div_unit_word_ex ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
                        quo_neg_q <= sa ^ sb;
                        rem_neg_q <= sa;
                        rem_op_q  <= is_rem;
                        word_q    <= i_div_unit_word_ex;
                        if (special) result_q <= div_fmt(special_res, i_div_unit_word_ex);
                    end
                end
                DIV_CALC: begin
                    rem_q <= take ? (rem_sh[63:0] - dvs_q) : rem_sh[63:0];
                    quo_q <= {quo_q[62:0], take};
                    cnt_q <= cnt_q - 7'd1;
                end
                DIV_FIX: begin
                    if (!i_div_unit_flush_ex) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign o_div_unit_done      = (state_q == DIV_DONE) & ~i_div_unit_flush_ex;
    assign o_div_unit_stall_req = i_div_unit_valid_ex & ~o_div_unit_done;
    assign o_div_unit_result    = result_q;

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// Directed bench for riscv_core_div_unit: latency, results, stall, flush, reset and early-out.
// Build with RISCV_CORE_DIV_EARLY_OUT_EN to exercise the early-out latency expectations.
module tb_riscv_core_div_unit;
    import riscv_core_pkg::*;

`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
    localparam bit EARLY_ON = 1'b1;
`else
    localparam bit EARLY_ON = 1'b0;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, word = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] srca = '0, srcb = '0;
    logic        stall, done;
    logic [63:0] result;
    int errors = 0, checks = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    riscv_core_div_unit #(.XLEN(64)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_div_unit_valid_ex (valid),
        .i_div_unit_op_ex    (op),
        .i_div_unit_word_ex  (word),
        .i_div_unit_srca_ex  (srca),
        .i_div_unit_srcb_ex  (srcb),
        .i_div_unit_flush_ex (flush),
        .o_div_unit_stall_req(stall),
        .o_div_unit_done     (done),
        .o_div_unit_result   (result)
    );

    // Called #1 after a posedge; returns #1 after the posedge that follows the done cycle, valid still held.
    task automatic run_op(input vec_t v, output int lat, output logic [63:0] res,
                          output int stall_cyc, output logic stall_at_done);
        valid = 1'b1; op = v.op; word = v.word; srca = v.a; srcb = v.b;
        lat = -1; res = 'x; stall_cyc = 0; stall_at_done = 1'bx;
        @(negedge clk);
        if (stall === 1'b1) stall_cyc++;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) begin
                lat = k; res = result; stall_at_done = stall;
                break;
            end
            if (stall === 1'b1) stall_cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; op = DIV_OP_DIVU; srca = 64'd100; srcb = 64'd7;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_valid: got %b expected 1", stall); end
        @(posedge clk); #1; valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_divide();
        vec_t tbl [8];
        int lat, sc; logic [63:0] res; logic sd;
        tbl = '{
            '{DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66},
            '{DIV_OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66},
            '{DIV_OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66},
            '{DIV_OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66},
            '{DIV_OP_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66},
            '{DIV_OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66},
            '{DIV_OP_DIVU, 1'b0, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66},
            '{DIV_OP_REMU, 1'b0, ONES, 64'd2, 64'd1, 66}
        };
        foreach (tbl[i]) begin
            run_op(tbl[i], lat, res, sc, sd);
            valid = 1'b0;
            checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            checks++; if (res !== tbl[i].exp) begin errors++; $display("FAIL div[%0d]_result: got %h expected %h", i, res, tbl[i].exp); end
            checks++; if (sc !== tbl[i].lat) begin errors++; $display("FAIL div[%0d]_stall_cycles: got %0d expected %0d", i, sc, tbl[i].lat); end
            checks++; if (sd !== 1'b0) begin errors++; $display("FAIL div[%0d]_stall_at_done: got %b expected 0", i, sd); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL div[%0d]_done_pulse_width: got %b expected 0", i, done); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        vec_t tbl [6];
        int lat, sc; logic [63:0] res; logic sd;
        tbl = '{
            '{DIV_OP_DIV,  1'b0, 64'd5, 64'd0, ONES, 1},
            '{DIV_OP_REM,  1'b0, 64'd5, 64'd0, 64'd5, 1},
            '{DIV_OP_DIVU, 1'b0, 64'd5, 64'd0, ONES, 1},
            '{DIV_OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1},
            '{DIV_OP_DIV,  1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1},
            '{DIV_OP_REM,  1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1}
        };
        foreach (tbl[i]) begin
            run_op(tbl[i], lat, res, sc, sd);
            valid = 1'b0;
            checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL special[%0d]_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            checks++; if (res !== tbl[i].exp) begin errors++; $display("FAIL special[%0d]_result: got %h expected %h", i, res, tbl[i].exp); end
            checks++; if (sc !== tbl[i].lat) begin errors++; $display("FAIL special[%0d]_stall_cycles: got %0d expected %0d", i, sc, tbl[i].lat); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL special[%0d]_done_pulse_width: got %b expected 0", i, done); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_word();
        vec_t tbl [6];
        int lat, sc; logic [63:0] res; logic sd;
        tbl = '{
            '{DIV_OP_DIV,  1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1},
            '{DIV_OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 34},
            '{DIV_OP_DIV,  1'b1, 64'h0000_0001_0000_0014, 64'd6, 64'd3, 34},
            '{DIV_OP_REMU, 1'b1, 64'h0000_0001_0000_0014, 64'd6, 64'd2, 34},
            '{DIV_OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 34},
            '{DIV_OP_DIVU, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, ONES, 1}
        };
        foreach (tbl[i]) begin
            run_op(tbl[i], lat, res, sc, sd);
            valid = 1'b0;
            checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL word[%0d]_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            checks++; if (res !== tbl[i].exp) begin errors++; $display("FAIL word[%0d]_result: got %h expected %h", i, res, tbl[i].exp); end
            checks++; if (sd !== 1'b0) begin errors++; $display("FAIL word[%0d]_stall_at_done: got %b expected 0", i, sd); end
            @(negedge clk); @(posedge clk); #1;
        end
    endtask

    task automatic test_early_out();
        vec_t tbl [3];
        int lat, sc; logic [63:0] res; logic sd;
        tbl = '{
            '{DIV_OP_DIVU, 1'b0, 64'd3, 64'd9, 64'd0, EARLY_ON ? 1 : 66},
            '{DIV_OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 64'hFFFF_FFFF_FFFF_FFFD, EARLY_ON ? 1 : 66},
            '{DIV_OP_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h0000_0000_8000_0007, 64'hFFFF_FFFF_8000_0005, EARLY_ON ? 1 : 34}
        };
        foreach (tbl[i]) begin
            run_op(tbl[i], lat, res, sc, sd);
            valid = 1'b0;
            checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL early[%0d]_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            checks++; if (res !== tbl[i].exp) begin errors++; $display("FAIL early[%0d]_result: got %h expected %h", i, res, tbl[i].exp); end
            @(negedge clk); @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, sc; logic [63:0] res1, res2; logic sd;
        run_op('{DIV_OP_DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, 66}, lat1, res1, sc, sd);
        run_op('{DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 66}, lat2, res2, sc, sd);
        valid = 1'b0;
        checks++; if (res1 !== 64'd100) begin errors++; $display("FAIL b2b_first_result: got %h expected 64", res1); end
        checks++; if (lat2 !== 66) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 66", lat2); end
        checks++; if (res2 !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL b2b_second_result: got %h expected fffffffffffffffa", res2); end
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int pulses, lat, sc; logic [63:0] res; logic sd;
        valid = 1'b1; op = DIV_OP_DIVU; word = 1'b0; srca = 64'd1000; srcb = 64'd3;
        repeat (20) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_calc_done: got %b expected 0", done); end
        @(posedge clk); #1; flush = 1'b0; valid = 1'b0;
        pulses = 0;
        repeat (80) begin @(negedge clk); if (done !== 1'b0) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_calc_no_result: got %0d pulses expected 0", pulses); end
        @(posedge clk); #1;
        // Flush on the accept cycle: a divide-by-zero would otherwise finish next cycle.
        valid = 1'b1; flush = 1'b1; op = DIV_OP_DIV; srca = 64'd5; srcb = 64'd0;
        @(posedge clk); #1; valid = 1'b0; flush = 1'b0;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (done !== 1'b0) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_accept_no_result: got %0d pulses expected 0", pulses); end
        @(posedge clk); #1;
        // Flush landing in the DONE cycle masks the pulse.
        valid = 1'b1;
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_gated: got %b expected 0", done); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_done_stall: got %b expected 1", stall); end
        @(posedge clk); #1; flush = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        run_op('{DIV_OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66}, lat, res, sc, sd);
        valid = 1'b0;
        checks++; if (lat !== 66) begin errors++; $display("FAIL flush_recover_latency: got %0d expected 66", lat); end
        checks++; if (res !== 64'd3) begin errors++; $display("FAIL flush_recover_result: got %h expected 3", res); end
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int pulses, lat, sc; logic [63:0] res; logic sd;
        valid = 1'b1; op = DIV_OP_DIVU; word = 1'b0; srca = 64'd100; srcb = 64'd7;
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        @(posedge clk); #1; rst_n = 1'b1; valid = 1'b0;
        pulses = 0;
        repeat (80) begin @(negedge clk); if (done !== 1'b0) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d pulses expected 0", pulses); end
        @(posedge clk); #1;
        run_op('{DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66}, lat, res, sc, sd);
        valid = 1'b0;
        checks++; if (res !== 64'd14 || lat !== 66) begin errors++; $display("FAIL rst_mid_recover: got %h at %0d expected e at 66", res, lat); end
        @(negedge clk); @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divide();
        test_special();
        test_word();
        test_early_out();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
